csr_regfile: RTL and testbench

Control/status register file for the LoongArch pipeline. It answers the CSR, exception and `ertn` traffic that the write-back stage issues, and returns `csr_rvalue` combinationally for CSR reads in the same cycle. It commits exception state: CRMD, PRMD, ESTAT, ERA and BADV. It supplies the exception entry and return targets to fetch, runs the architectural timer, and raises the interrupt request.

---
 rtl/csr_regfile.sv | 245 ++++++++++++++++++++++++
 tb/tb_csr_regfile.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// csr_regfile: LoongArch control/status register file.
// Holds CRMD/PRMD/ECFG/ESTAT/ERA/BADV/EENTRY/SAVE0-3/TID, commits exception
// and ertn state, and raises the interrupt request.
// Optional macro CSR_TIMER_EN adds TCFG/TVAL/TICLR and the timer interrupt.
module csr_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] csr_num,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wdata,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        eret_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] csr_rvalue,
    output logic [31:0] ex_entry,
    output logic [31:0] era_pc,
    output logic        has_int
);

    localparam logic [13:0] AddrCrmd   = 14'h00;
    localparam logic [13:0] AddrPrmd   = 14'h01;
    localparam logic [13:0] AddrEcfg   = 14'h04;
    localparam logic [13:0] AddrEstat  = 14'h05;
    localparam logic [13:0] AddrEra    = 14'h06;
    localparam logic [13:0] AddrBadv   = 14'h07;
    localparam logic [13:0] AddrEentry = 14'h0C;
    localparam logic [13:0] AddrSave0  = 14'h30;
    localparam logic [13:0] AddrSave1  = 14'h31;
    localparam logic [13:0] AddrSave2  = 14'h32;
    localparam logic [13:0] AddrSave3  = 14'h33;
    localparam logic [13:0] AddrTid    = 14'h40;
`ifdef CSR_TIMER_EN
    localparam logic [13:0] AddrTcfg   = 14'h41;
    localparam logic [13:0] AddrTval   = 14'h42;
    localparam logic [13:0] AddrTiclr  = 14'h44;
`endif
    localparam logic [5:0]  EcodeAdef  = 6'h08;
    localparam logic [5:0]  EcodeAle   = 6'h09;
    // ECFG.LIE bit 10 does not exist
    localparam logic [12:0] LieMask    = 13'h1BFF;

    logic [1:0]       plv_q, plv_d;
    logic             ie_q, ie_d, da_q, da_d, pg_q, pg_d;
    logic [1:0]       pplv_q, pplv_d;
    logic             pie_q, pie_d;
    logic [12:0]      lie_q, lie_d;
    logic [1:0]       is_sw_q, is_sw_d;
    logic [7:0]       is_hw_q;
    logic             is_ipi_q;
    logic             is_timer_q, is_timer_d;
    logic [5:0]       ecode_q, ecode_d;
    logic [8:0]       esubcode_q, esubcode_d;
    logic [31:0]      era_q, era_d, badv_q, badv_d, tid_q, tid_d;
    logic [25:0]      eentry_q, eentry_d;
    logic [3:0][31:0] save_q, save_d;
`ifdef CSR_TIMER_EN
    logic [31:0]      tcfg_q, tcfg_d, tval_q, tval_d;
    logic             tcfg_wr, ticlr_wr;
`endif

    logic [12:0] is_val;
    logic [31:0] wr;

    assign is_val   = {is_ipi_q, is_timer_q, 1'b0, is_hw_q, is_sw_q};
    assign ex_entry = {eentry_q, 6'b0};
    assign era_pc   = era_q;
    assign has_int  = ie_q & (|(lie_q & is_val));

    // Read mux: reserved bits and unlisted addresses read 0
    always_comb begin
        csr_rvalue = 32'h0;
        case (csr_num)
            AddrCrmd:   csr_rvalue = {27'b0, pg_q, da_q, ie_q, plv_q};
            AddrPrmd:   csr_rvalue = {29'b0, pie_q, pplv_q};
            AddrEcfg:   csr_rvalue = {19'b0, lie_q};
            AddrEstat:  csr_rvalue = {1'b0, esubcode_q, ecode_q, 3'b0, is_val};
            AddrEra:    csr_rvalue = era_q;
            AddrBadv:   csr_rvalue = badv_q;
            AddrEentry: csr_rvalue = {eentry_q, 6'b0};
            AddrSave0:  csr_rvalue = save_q[0];
            AddrSave1:  csr_rvalue = save_q[1];
            AddrSave2:  csr_rvalue = save_q[2];
            AddrSave3:  csr_rvalue = save_q[3];
            AddrTid:    csr_rvalue = tid_q;
`ifdef CSR_TIMER_EN
            AddrTcfg:   csr_rvalue = tcfg_q;
            AddrTval:   csr_rvalue = tval_q;
`endif
            default:    csr_rvalue = 32'h0;
        endcase
    end

    // Next state: exception beats ertn beats software write; the loser is dropped
    always_comb begin
        plv_d      = plv_q;
        ie_d       = ie_q;
        da_d       = da_q;
        pg_d       = pg_q;
        pplv_d     = pplv_q;
        pie_d      = pie_q;
        lie_d      = lie_q;
        is_sw_d    = is_sw_q;
        ecode_d    = ecode_q;
        esubcode_d = esubcode_q;
        era_d      = era_q;
        badv_d     = badv_q;
        eentry_d   = eentry_q;
        save_d     = save_q;
        tid_d      = tid_q;
        // csr_rvalue is the pre-edge value of the addressed CSR
        wr         = (csr_rvalue & ~csr_wmask) | (csr_wdata & csr_wmask);
`ifdef CSR_TIMER_EN
        tcfg_d     = tcfg_q;
        tval_d     = tval_q;
        tcfg_wr    = 1'b0;
        ticlr_wr   = 1'b0;
        is_timer_d = is_timer_q;
`else
        is_timer_d = 1'b0;
`endif
        if (wb_ex) begin
            pplv_d     = plv_q;
            pie_d      = ie_q;
            plv_d      = 2'b0;
            ie_d       = 1'b0;
            ecode_d    = wb_ecode;
            esubcode_d = wb_esubcode;
            era_d      = wb_pc;
            if (wb_ecode == EcodeAdef) begin
                badv_d = wb_pc;
            end else if (wb_ecode == EcodeAle) begin
                badv_d = wb_vaddr;
            end
        end else if (eret_flush) begin
            plv_d = pplv_q;
            ie_d  = pie_q;
        end else if (csr_we) begin
            case (csr_num)
                AddrCrmd: begin
                    plv_d = wr[1:0];
                    ie_d  = wr[2];
                    da_d  = wr[3];
                    pg_d  = wr[4];
                end
                AddrPrmd: begin
                    pplv_d = wr[1:0];
                    pie_d  = wr[2];
                end
                AddrEcfg:   lie_d     = wr[12:0] & LieMask;
                AddrEstat:  is_sw_d   = wr[1:0];
                AddrEra:    era_d     = wr;
                AddrBadv:   badv_d    = wr;
                AddrEentry: eentry_d  = wr[31:6];
                AddrSave0:  save_d[0] = wr;
                AddrSave1:  save_d[1] = wr;
                AddrSave2:  save_d[2] = wr;
                AddrSave3:  save_d[3] = wr;
                AddrTid:    tid_d     = wr;
`ifdef CSR_TIMER_EN
                AddrTcfg: begin
                    tcfg_d  = wr;
                    tcfg_wr = 1'b1;
                end
                AddrTiclr:  ticlr_wr  = csr_wdata[0] & csr_wmask[0];
`endif
                default: ;
            endcase
        end
`ifdef CSR_TIMER_EN
        // Timer: a TCFG write reloads; the 1->0 step raises IS[11] over any clear
        if (tcfg_wr) begin
            tval_d = {tcfg_d[31:2], 2'b00};
        end else if (tcfg_q[0]) begin
            if (tval_q != 32'h0) begin
                tval_d = tval_q - 32'h1;
            end else if (tcfg_q[1]) begin
                tval_d = {tcfg_q[31:2], 2'b00};
            end
        end
        if (tcfg_q[0] && !tcfg_wr && tval_q == 32'h1) begin
            is_timer_d = 1'b1;
        end else if (ticlr_wr) begin
            is_timer_d = 1'b0;
        end
`endif
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            plv_q      <= 2'b0;
            ie_q       <= 1'b0;
            da_q       <= 1'b1;
            pg_q       <= 1'b0;
            pplv_q     <= 2'b0;
            pie_q      <= 1'b0;
            lie_q      <= 13'h0;
            is_sw_q    <= 2'b0;
            is_hw_q    <= 8'h0;
            is_ipi_q   <= 1'b0;
            is_timer_q <= 1'b0;
            ecode_q    <= 6'h0;
            esubcode_q <= 9'h0;
            era_q      <= 32'h0;
            badv_q     <= 32'h0;
            eentry_q   <= 26'h0;
            save_q     <= '0;
            tid_q      <= 32'h0;
`ifdef CSR_TIMER_EN
            tcfg_q     <= 32'h0;
            tval_q     <= 32'h0;
`endif
        end else begin
            plv_q      <= plv_d;
            ie_q       <= ie_d;
            da_q       <= da_d;
            pg_q       <= pg_d;
            pplv_q     <= pplv_d;
            pie_q      <= pie_d;
            lie_q      <= lie_d;
            is_sw_q    <= is_sw_d;
            is_hw_q    <= hw_int_in;
            is_ipi_q   <= ipi_int_in;
            is_timer_q <= is_timer_d;
            ecode_q    <= ecode_d;
            esubcode_q <= esubcode_d;
            era_q      <= era_d;
            badv_q     <= badv_d;
            eentry_q   <= eentry_d;
            save_q     <= save_d;
            tid_q      <= tid_d;
`ifdef CSR_TIMER_EN
            tcfg_q     <= tcfg_d;
            tval_q     <= tval_d;
`endif
        end
    end

endmodule

// File: tb/tb_csr_regfile.sv
// Scoreboard bench for csr_regfile: stimulus queues expectations, a
// negedge monitor pops and compares. Timer checks follow CSR_TIMER_EN.
module tb_csr_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask, csr_wdata;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc, wb_vaddr;
    logic        eret_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] csr_rvalue, ex_entry, era_pc;
    logic        has_int;

    csr_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .csr_num    (csr_num),
        .csr_we     (csr_we),
        .csr_wmask  (csr_wmask),
        .csr_wdata  (csr_wdata),
        .wb_ex      (wb_ex),
        .wb_ecode   (wb_ecode),
        .wb_esubcode(wb_esubcode),
        .wb_pc      (wb_pc),
        .wb_vaddr   (wb_vaddr),
        .eret_flush (eret_flush),
        .hw_int_in  (hw_int_in),
        .ipi_int_in (ipi_int_in),
        .csr_rvalue (csr_rvalue),
        .ex_entry   (ex_entry),
        .era_pc     (era_pc),
        .has_int    (has_int)
    );

    always #5 clk = ~clk;

    localparam int KRv = 0, KInt = 1, KEntry = 2, KEra = 3;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // Monitor: compare every queued expectation against the live outputs
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                KRv:     act = csr_rvalue;
                KInt:    act = {31'b0, has_int};
                KEntry:  act = ex_entry;
                default: act = era_pc;
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_(input int kind, input logic [31:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic rd(input logic [13:0] addr, input logic [31:0] exp, input string name);
        csr_num = addr;
        expect_(KRv, exp, name);
        tick();
    endtask

    task automatic wr(input logic [13:0] addr, input logic [31:0] mask, input logic [31:0] data);
        csr_num   = addr;
        csr_we    = 1'b1;
        csr_wmask = mask;
        csr_wdata = data;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic ex(input logic [5:0] code, input logic [31:0] pc, input logic [31:0] va);
        wb_ex    = 1'b1;
        wb_ecode = code;
        wb_pc    = pc;
        wb_vaddr = va;
        tick();
        wb_ex    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; csr_num = 14'h0; csr_we = 1'b0; csr_wmask = 32'h0; csr_wdata = 32'h0;
        wb_ex = 1'b0; wb_ecode = 6'h0; wb_esubcode = 9'h0; wb_pc = 32'h0; wb_vaddr = 32'h0;
        eret_flush = 1'b0; hw_int_in = 8'h0; ipi_int_in = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        expect_(KInt, 32'h0, "rst_has_int");
        expect_(KEntry, 32'h0, "rst_ex_entry");
        expect_(KEra, 32'h0, "rst_era_pc");
        rd(14'h00, 32'h8, "rst_crmd");
        rd(14'h05, 32'h0, "rst_estat");
        rd(14'h06, 32'h0, "rst_era");
        rd(14'h01, 32'h0, "rst_prmd");

        // Masked SAVE0 write: old value during the write cycle, merged value after
        csr_num = 14'h30; csr_we = 1'b1; csr_wmask = 32'hFFFF_0000; csr_wdata = 32'hDEAD_BEEF;
        expect_(KRv, 32'h0, "save0_rdw");
        tick();
        csr_we = 1'b0;
        rd(14'h30, 32'hDEAD_0000, "save0_after");

        // ALE exception then ertn
        wr(14'h00, 32'h7, 32'h7);
        rd(14'h00, 32'hF, "crmd_wr");
        ex(6'h09, 32'h1C00_0100, 32'h1003);
        rd(14'h01, 32'h7, "ale_prmd");
        rd(14'h00, 32'h8, "ale_crmd");
        rd(14'h06, 32'h1C00_0100, "ale_era");
        rd(14'h07, 32'h1003, "ale_badv");
        expect_(KEra, 32'h1C00_0100, "ale_era_pc");
        rd(14'h05, 32'h0009_0000, "ale_estat");
        eret_flush = 1'b1;
        tick();
        eret_flush = 1'b0;
        rd(14'h00, 32'hF, "ertn_crmd");

        // ADEF exception with a colliding ERA write: write dropped
        csr_num = 14'h06; csr_we = 1'b1; csr_wmask = 32'hFFFF_FFFF; csr_wdata = 32'h1234;
        ex(6'h08, 32'h2000, 32'h5555);
        csr_we = 1'b0;
        rd(14'h06, 32'h2000, "adef_era");
        rd(14'h07, 32'h2000, "adef_badv");
        // Other ecode leaves BADV alone
        ex(6'h0B, 32'h3000, 32'h7777);
        rd(14'h07, 32'h2000, "sys_badv");
        rd(14'h05, 32'h000B_0000, "sys_estat");
        // ertn beats a SAVE1 write
        csr_num = 14'h31; csr_we = 1'b1; csr_wmask = 32'hFFFF_FFFF; csr_wdata = 32'h55;
        eret_flush = 1'b1;
        tick();
        eret_flush = 1'b0; csr_we = 1'b0;
        rd(14'h31, 32'h0, "ertn_drops_save1");
        rd(14'h00, 32'h8, "ertn2_crmd");

        // EENTRY low bits, ECFG bit 10, TID, unlisted address
        wr(14'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_(KEntry, 32'hFFFF_FFC0, "ex_entry");
        rd(14'h0C, 32'hFFFF_FFC0, "eentry");
        wr(14'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(14'h04, 32'h1BFF, "ecfg_bit10");
        wr(14'h40, 32'hFFFF_FFFF, 32'h1234_5678);
        rd(14'h40, 32'h1234_5678, "tid");
        wr(14'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(14'h10, 32'h0, "unlisted");

        // Hardware interrupt: one-cycle latency into IS and has_int
        wr(14'h04, 32'hFFFF_FFFF, 32'h4);
        wr(14'h00, 32'h4, 32'h4);
        hw_int_in = 8'h01;
        expect_(KInt, 32'h0, "hw_int_latency");
        tick();
        expect_(KInt, 32'h1, "hw_int_set");
        rd(14'h05, 32'h000B_0004, "estat_is2");
        wr(14'h04, 32'h4, 32'h0);
        expect_(KInt, 32'h0, "hw_int_masked");
        hw_int_in = 8'h00;
        tick();

        // Software IS[1:0] is the only writable ESTAT field
        wr(14'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(14'h05, 32'h000B_0003, "estat_sw");
        wr(14'h04, 32'hFFFF_FFFF, 32'h3);
        expect_(KInt, 32'h1, "sw_int");
        tick();
        wr(14'h05, 32'h3, 32'h0);
        ipi_int_in = 1'b1;
        tick();
        ipi_int_in = 1'b0;
        rd(14'h05, 32'h000B_1000, "estat_ipi");
        tick();

        // Timer
        wr(14'h04, 32'hFFFF_FFFF, 32'h800);
        wr(14'h41, 32'hFFFF_FFFF, 32'h13);
`ifdef CSR_TIMER_EN
        for (int i = 16; i >= 1; i--) begin
            if (i == 1) expect_(KInt, 32'h0, "timer_pre");
            rd(14'h42, 32'(i), $sformatf("tval_%0d", i));
        end
        expect_(KInt, 32'h1, "timer_irq");
        rd(14'h42, 32'h0, "tval_0");
        rd(14'h42, 32'd16, "tval_reload");
        rd(14'h05, 32'h000B_0800, "estat_is11");
        wr(14'h44, 32'h1, 32'h1);
        expect_(KInt, 32'h0, "ticlr_irq");
        rd(14'h05, 32'h000B_0000, "ticlr_estat");
        rd(14'h44, 32'h0, "ticlr_reads0");
`else
        rd(14'h41, 32'h0, "tcfg_absent");
        rd(14'h42, 32'h0, "tval_absent");
        tick(); tick(); tick(); tick();
        expect_(KInt, 32'h0, "no_timer_irq");
        rd(14'h05, 32'h000B_0000, "estat_no_is11");
`endif

        // Reset in the middle of activity
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_(KInt, 32'h0, "rst2_has_int");
        expect_(KEntry, 32'h0, "rst2_ex_entry");
        rd(14'h00, 32'h8, "rst2_crmd");
        rd(14'h42, 32'h0, "rst2_tval");
        tick();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
